dma_peripheral_responder: RTL and testbench
===========================================

// Module: dma_peripheral_responder
// PURPOSE
// - Peripheral-side end of the 8237-style DMA handshake; buffers bytes in TX/RX FIFOs.
// - Raises DREQ, waits for DACK, serves IOR_N reads (device->memory) or absorbs IOW_N
//   writes (memory->device), and accepts EOP_N as terminal count.
// - Sits between a local device and one DMA channel's DREQ/DACK pair on the shared bus.
// PARAMETERS
// DEPTH  8  entries per FIFO (power of 2, >=2); counters are $clog2(DEPTH)+1 bits
// DW     8  data bus width
// PORTS
// CLK         in   1   system clock, all logic on posedge
// RESET_N     in   1   asynchronous active-low reset
// DREQ        out  1   DMA request, active high, registered
// DACK        in   1   DMA acknowledge, active high
// IOR_N       in   1   I/O read strobe, active low (device drives bus)
// IOW_N       in   1   I/O write strobe, active low (device captures bus)
// EOP_N       in   1   end of process / terminal count, active low
// DB_IN       in   DW  data bus in
// DB_OUT      out  DW  data bus out
// DB_OE       out  1   bus output enable
// enable      in   1   channel enable
// mode        in   1   0 = device->memory (IOR_N), 1 = memory->device (IOW_N)
// burst       in   1   1 = demand mode (DREQ held while ready), 0 = single transfer
// tx_wr_en    in   1   push tx_wr_data into TX FIFO
// tx_wr_data  in   DW  local TX data
// tx_full     out  1   TX count == DEPTH
// rx_rd_en    in   1   pop RX FIFO; rx_rd_data valid same cycle (show-ahead)
// rx_rd_data  out  DW  RX FIFO head
// rx_empty    out  1   RX count == 0
// tc_flag     out  1   terminal count seen, sticky
// tc_clear    in   1   clears tc_flag
// err_flag    out  1   sticky underrun/overrun; cleared by tc_clear
// BEHAVIOUR
// - Reset: state=IDLE, FIFOs empty, DREQ=0, DB_OE=0, DB_OUT=0, tc_flag=0, err_flag=0,
//   tx_full=0, rx_empty=1, strobe registers = 1.
// - ready = enable & (mode ? rx_count<DEPTH : tx_count>0), from registered counts.
// - Strobe edges use registered copies: fall = q & !now, rise = !q & now.
//   Only the strobe matching mode is honoured while DACK=1; others are ignored.
// - DB_OE = DACK & !IOR_N & !mode, combinational. DB_OUT = TX head, 0 when TX empty.
// - IOR_N rise with DACK pops TX. An empty TX pop is an underrun: sets err_flag, no pop.
// - IOW_N low with DACK captures DB_IN every clock. IOW_N rise pushes the last captured
//   byte into RX. A full RX push is an overrun: sets err_flag, byte dropped.
// - The local port and the bus may push and pop the same FIFO in the same cycle; count
//   is unchanged and both actions take effect. Pointers wrap modulo DEPTH.
// - FSM (DREQ = 1 in REQ and XFER only):
//   IDLE: ready & !tc_flag -> REQ.
//   REQ: DACK -> XFER; !enable -> IDLE.
//   XFER: eop_pend latches on EOP_N low while DACK=1.
//     At strobe rise: eop_pend -> TC; else burst & ready_next -> XFER; else -> RECOVER.
//     ready_next includes this cycle's push/pop.
//     DACK drop without strobe -> RECOVER (eop_pend -> TC).
//   RECOVER: one cycle, DREQ=0, -> IDLE (DREQ low >= 1 clk between single transfers).
//   TC: DREQ=0, tc_flag=1; tc_clear -> IDLE with eop_pend cleared.
// - Latency: count update at edge k means DREQ is high after edge k+1.
//   DREQ falls the clock after the completing strobe rise.
// - tc_clear and EOP_N in the same cycle: the EOP_N wins and tc_flag stays set.
// - Reset asserted mid-transfer: immediate return to reset values. Any in-flight byte is lost.
// TESTING
// - mode=0, push 0xA5; DACK up 2 clk after DREQ; IOR_N low 2 clk -> DB_OE=1,
//   DB_OUT=0xA5, TX empty after rise, DREQ low next clk, RECOVER then IDLE.
// - mode=1, burst=1, DACK held, 3 IOW_N pulses with 0x11/0x22/0x33 -> RX pops in order
//   11,22,33; DREQ high throughout; drops after DEPTH bytes (RX full).
// - mode=0, TX 3 bytes, EOP_N low during 2nd IOR_N -> TC after 2nd rise; 1 byte left;
//   DREQ stays 0 until tc_clear, then re-requests.
// - Fill TX to DEPTH -> tx_full=1; 9th push ignored. Same-cycle push+pop at full:
//   count stays DEPTH, order preserved across pointer wrap.
// - Overrun/underrun: IOW_N with RX full, then forced IOR_N with TX empty ->
//   err_flag=1, DB_OUT=0, counts unchanged.
// - RESET_N low mid-XFER (IOR_N low) -> DREQ=0, DB_OE=0, FIFOs empty within same cycle.

Source files
------------

// File: rtl/dma_peripheral_responder.sv
// dma_peripheral_responder
// Peripheral end of an 8237-style DMA handshake. Local TX/RX FIFOs decouple
// the device from the bus: DREQ is raised when the selected direction can
// move a byte, IOR_N rises pop TX onto the bus, IOW_N pulses capture bus data
// into RX, and EOP_N ends the process with a sticky terminal-count flag.
// Ports:
//   CLK, RESET_N          clock / asynchronous active-low reset
//   DREQ, DACK            DMA request (registered) / acknowledge
//   IOR_N, IOW_N, EOP_N   active-low bus strobes and terminal count
//   DB_IN, DB_OUT, DB_OE  data bus in, out and output enable
//   enable, mode, burst   channel enable, direction (1 = mem->dev), demand mode
//   tx_wr_en/tx_wr_data/tx_full   local TX FIFO push side
//   rx_rd_en/rx_rd_data/rx_empty  local RX FIFO pop side (show-ahead)
//   tc_flag, tc_clear, err_flag   sticky status and their clear
module dma_peripheral_responder #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  output logic          DREQ,
  input  logic          DACK,
  input  logic          IOR_N,
  input  logic          IOW_N,
  input  logic          EOP_N,
  input  logic [DW-1:0] DB_IN,
  output logic [DW-1:0] DB_OUT,
  output logic          DB_OE,
  input  logic          enable,
  input  logic          mode,
  input  logic          burst,
  input  logic          tx_wr_en,
  input  logic [DW-1:0] tx_wr_data,
  output logic          tx_full,
  input  logic          rx_rd_en,
  output logic [DW-1:0] rx_rd_data,
  output logic          rx_empty,
  output logic          tc_flag,
  input  logic          tc_clear,
  output logic          err_flag
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_RECOVER,
    S_TC
  } state_e;

  state_e          state_q, state_d;
  logic            dreq_q, dreq_d;
  logic            tc_flag_q, tc_flag_d;
  logic            err_q, err_d;
  logic            eop_pend_q, eop_pend_d;
  logic            ior_q, iow_q;
  logic [DW-1:0]   cap_q, cap_d;

  logic [DW-1:0]   tx_mem_q [DEPTH];
  logic [DW-1:0]   tx_mem_d [DEPTH];
  logic [PW-1:0]   tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CW-1:0]   tx_count_q, tx_count_d;

  logic [DW-1:0]   rx_mem_q [DEPTH];
  logic [DW-1:0]   rx_mem_d [DEPTH];
  logic [PW-1:0]   rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0]   rx_count_q, rx_count_d;

  logic ior_rise, iow_rise;
  logic bus_pop_req, bus_push_req, strobe_rise;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic underrun, overrun;
  logic ready, ready_next, eop_now;

  // FIFO and strobe datapath
  always_comb begin
    ior_rise     = ~ior_q & IOR_N;
    iow_rise     = ~iow_q & IOW_N;
    bus_pop_req  = DACK & ~mode & ior_rise;
    bus_push_req = DACK &  mode & iow_rise;
    strobe_rise  = bus_pop_req | bus_push_req;

    // A full FIFO still accepts a push when the other side pops in the same cycle.
    tx_pop   = bus_pop_req & (tx_count_q != '0);
    underrun = bus_pop_req & (tx_count_q == '0);
    tx_push  = tx_wr_en & ((tx_count_q != FULL_CNT) | tx_pop);

    rx_pop   = rx_rd_en & (rx_count_q != '0);
    rx_push  = bus_push_req & ((rx_count_q != FULL_CNT) | rx_pop);
    overrun  = bus_push_req & ~((rx_count_q != FULL_CNT) | rx_pop);

    tx_mem_d    = tx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = tx_wr_data;
      tx_wr_ptr_d           = tx_wr_ptr_q + 1'b1;
    end
    if (tx_pop) tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + 1'b1;
      2'b01:   tx_count_d = tx_count_q - 1'b1;
      default: tx_count_d = tx_count_q;
    endcase

    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = cap_q;
      rx_wr_ptr_d           = rx_wr_ptr_q + 1'b1;
    end
    if (rx_pop) rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + 1'b1;
      2'b01:   rx_count_d = rx_count_q - 1'b1;
      default: rx_count_d = rx_count_q;
    endcase

    // IOW_N rise carries no data; the byte is the last one sampled while low.
    cap_d = (DACK & mode & ~IOW_N) ? DB_IN : cap_q;

    err_d = underrun | overrun | (err_q & ~tc_clear);

    ready      = enable & (mode ? (rx_count_q != FULL_CNT) : (tx_count_q != '0));
    ready_next = enable & (mode ? (rx_count_d != FULL_CNT) : (tx_count_d != '0));
  end

  // Handshake FSM
  always_comb begin
    state_d    = state_q;
    eop_pend_d = eop_pend_q;
    eop_now    = DACK & ~EOP_N;
    case (state_q)
      S_IDLE: begin
        if (ready && !tc_flag_q) state_d = S_REQ;
      end
      S_REQ: begin
        if (DACK)         state_d = S_XFER;
        else if (!enable) state_d = S_IDLE;
      end
      S_XFER: begin
        // EOP_N coinciding with the completing strobe still counts.
        eop_pend_d = eop_pend_q | eop_now;
        if (strobe_rise) begin
          if (eop_pend_d)               state_d = S_TC;
          else if (burst && ready_next) state_d = S_XFER;
          else                          state_d = S_RECOVER;
        end else if (!DACK) begin
          state_d = eop_pend_d ? S_TC : S_RECOVER;
        end
      end
      S_RECOVER: state_d = S_IDLE;
      S_TC: begin
        if (tc_clear && !eop_now) begin
          state_d    = S_IDLE;
          eop_pend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    dreq_d    = (state_d == S_REQ) || (state_d == S_XFER);
    tc_flag_d = (state_d == S_TC);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      dreq_q      <= 1'b0;
      tc_flag_q   <= 1'b0;
      err_q       <= 1'b0;
      eop_pend_q  <= 1'b0;
      ior_q       <= 1'b1;
      iow_q       <= 1'b1;
      cap_q       <= '0;
      tx_mem_q    <= '{default: '0};
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_mem_q    <= '{default: '0};
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      dreq_q      <= dreq_d;
      tc_flag_q   <= tc_flag_d;
      err_q       <= err_d;
      eop_pend_q  <= eop_pend_d;
      ior_q       <= IOR_N;
      iow_q       <= IOW_N;
      cap_q       <= cap_d;
      tx_mem_q    <= tx_mem_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_mem_q    <= rx_mem_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
    end
  end

  assign DREQ       = dreq_q;
  assign tc_flag    = tc_flag_q;
  assign err_flag   = err_q;
  assign tx_full    = (tx_count_q == FULL_CNT);
  assign rx_empty   = (rx_count_q == '0);
  assign DB_OUT     = (tx_count_q == '0) ? '0 : tx_mem_q[tx_rd_ptr_q];
  assign rx_rd_data = (rx_count_q == '0) ? '0 : rx_mem_q[rx_rd_ptr_q];
  // Gated by reset so the bus is released the moment reset asserts.
  assign DB_OE      = RESET_N & DACK & ~IOR_N & ~mode;

endmodule

// File: tb/tb_dma_peripheral_responder.sv
// Bench for dma_peripheral_responder: reset values, a table of TX FIFO
// vectors including full/wrap, hand-written handshake sequences, and a
// randomized FIFO/strobe phase against a queue-based reference model.
module tb_dma_peripheral_responder;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       DREQ, DACK, IOR_N, IOW_N, EOP_N;
  logic [7:0] DB_IN, DB_OUT;
  logic       DB_OE;
  logic       enable, mode, burst;
  logic       tx_wr_en;
  logic [7:0] tx_wr_data;
  logic       tx_full;
  logic       rx_rd_en;
  logic [7:0] rx_rd_data;
  logic       rx_empty, tc_flag, tc_clear, err_flag;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  dma_peripheral_responder #(.DEPTH(8), .DW(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DACK(DACK),
    .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
    .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
    .enable(enable), .mode(mode), .burst(burst),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty),
    .tc_flag(tc_flag), .tc_clear(tc_clear), .err_flag(err_flag)
  );

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       dack;
    logic       ior_n;
    logic       exp_full;
    logic [7:0] exp_out;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] drain_exp [8] = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h20, 8'h21, 8'h22, 8'h00};
  logic [7:0] pat [8]       = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  // Reference model state for the randomized phase
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  logic       m_prev_ior, m_prev_iow, m_err;
  logic [7:0] m_cap;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    DACK = 0; IOR_N = 1; IOW_N = 1; EOP_N = 1; DB_IN = '0;
    enable = 0; mode = 0; burst = 0;
    tx_wr_en = 0; tx_wr_data = '0; rx_rd_en = 0; tc_clear = 0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] data, input logic dack,
                              input logic ior_n, input logic full, input logic [7:0] out);
    vec_t v;
    v.wr = wr; v.data = data; v.dack = dack; v.ior_n = ior_n;
    v.exp_full = full; v.exp_out = out;
    return v;
  endfunction

  initial begin
    // Reset values
    do_reset();
    chk("rst_dreq", DREQ, 0);
    chk("rst_db_oe", DB_OE, 0);
    chk("rst_db_out", DB_OUT, 0);
    chk("rst_tc", tc_flag, 0);
    chk("rst_err", err_flag, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);

    // Table: fill TX, overfill, push+pop at full across wrap, drain
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 8'h10 + 8'(i), 0, 1, i == 7, 8'h10));
    vecs.push_back(mk(1, 8'h99, 0, 1, 1, 8'h10));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h10 + 8'(k)));
      vecs.push_back(mk(1, 8'h20 + 8'(k), 1, 1, 1, 8'h11 + 8'(k)));
    end
    for (int j = 0; j < 8; j++) begin
      vecs.push_back(mk(0, 8'h00, 1, 0, j == 0, (j == 0) ? 8'h13 : drain_exp[j-1]));
      vecs.push_back(mk(0, 8'h00, 1, 1, 0, drain_exp[j]));
    end
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      tx_wr_en = vecs[i].wr; tx_wr_data = vecs[i].data;
      DACK = vecs[i].dack;   IOR_N = vecs[i].ior_n;
      tick();
      chk($sformatf("vec%0d_full", i), tx_full, vecs[i].exp_full);
      chk($sformatf("vec%0d_out", i), DB_OUT, vecs[i].exp_out);
    end
    chk("vec_err", err_flag, 0);

    // Single device->memory transfer
    do_reset();
    mode = 0; burst = 0; enable = 1;
    tx_wr_en = 1; tx_wr_data = 8'hA5;
    tick();
    tx_wr_en = 0;
    chk("t1_dreq_pre", DREQ, 0);
    tick();
    chk("t1_dreq", DREQ, 1);
    tick(); tick();
    DACK = 1;
    tick();
    IOR_N = 0; #1;
    chk("t1_oe", DB_OE, 1);
    chk("t1_out", DB_OUT, 8'hA5);
    tick(); tick();
    IOR_N = 1; #1;
    chk("t1_oe_off", DB_OE, 0);
    chk("t1_dreq_rise", DREQ, 1);
    tick();
    chk("t1_dreq_fall", DREQ, 0);
    chk("t1_out_empty", DB_OUT, 0);
    DACK = 0;
    tick();
    chk("t1_recover", DREQ, 0);
    tick();
    chk("t1_idle", DREQ, 0);

    // Demand-mode memory->device writes until RX full, then overrun/underrun
    do_reset();
    mode = 1; burst = 1; enable = 1;
    tick();
    chk("t2_dreq", DREQ, 1);
    DACK = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      IOW_N = 0; DB_IN = pat[i];
      tick();
      IOW_N = 1; DB_IN = 8'h00;
      tick();
      chk($sformatf("t2_dreq%0d", i), DREQ, i < 7);
    end
    IOW_N = 0; DB_IN = 8'hEE;
    tick();
    IOW_N = 1;
    tick();
    chk("t2_overrun", err_flag, 1);
    chk("t2_rx_nonempty", rx_empty, 0);
    tc_clear = 1;
    tick();
    tc_clear = 0;
    chk("t2_err_clr", err_flag, 0);
    enable = 0; mode = 0;
    IOR_N = 0;
    tick();
    IOR_N = 1; #1;
    chk("t2_under_out", DB_OUT, 0);
    tick();
    chk("t2_underrun", err_flag, 1);
    chk("t2_under_out2", DB_OUT, 0);
    chk("t2_tx_full", tx_full, 0);
    DACK = 0;
    rx_rd_en = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("t2_rx%0d", i), rx_rd_data, pat[i]);
      tick();
    end
    rx_rd_en = 0;
    chk("t2_rx_empty", rx_empty, 1);

    // Terminal count during the second read of a burst
    do_reset();
    mode = 0; burst = 1; enable = 1;
    tx_wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      tx_wr_data = 8'hC0 + 8'(i);
      tick();
    end
    tx_wr_en = 0;
    DACK = 1;
    tick();
    IOR_N = 0; tick();
    IOR_N = 1; tick();
    chk("t3_dreq_burst", DREQ, 1);
    chk("t3_head1", DB_OUT, 8'hC1);
    IOR_N = 0; EOP_N = 0; tick();
    IOR_N = 1; EOP_N = 1; tick();
    chk("t3_dreq_tc", DREQ, 0);
    chk("t3_tc", tc_flag, 1);
    chk("t3_left", DB_OUT, 8'hC2);
    DACK = 0;
    tick(); tick(); tick();
    chk("t3_dreq_hold", DREQ, 0);
    chk("t3_tc_hold", tc_flag, 1);
    tc_clear = 1; DACK = 1; EOP_N = 0;
    tick();
    chk("t3_eop_wins", tc_flag, 1);
    chk("t3_eop_dreq", DREQ, 0);
    DACK = 0; EOP_N = 1;
    tick();
    chk("t3_tc_clr", tc_flag, 0);
    chk("t3_idle", DREQ, 0);
    tc_clear = 0;
    tick();
    chk("t3_rereq", DREQ, 1);

    // Reset during an active read
    do_reset();
    mode = 0; enable = 1;
    tx_wr_en = 1; tx_wr_data = 8'h5A;
    tick();
    tx_wr_en = 0;
    tick();
    DACK = 1;
    tick();
    IOR_N = 0;
    tick();
    chk("t6_dreq_pre", DREQ, 1);
    chk("t6_oe_pre", DB_OE, 1);
    RESET_N = 0; #1;
    chk("t6_dreq", DREQ, 0);
    chk("t6_oe", DB_OE, 0);
    chk("t6_out", DB_OUT, 0);
    chk("t6_rx_empty", rx_empty, 1);
    chk("t6_tx_full", tx_full, 0);
    DACK = 0; IOR_N = 1;
    tick();
    RESET_N = 1;

    // Randomized FIFO/strobe traffic with the channel disabled
    do_reset();
    tx_m.delete(); rx_m.delete();
    m_prev_ior = 1; m_prev_iow = 1; m_err = 0; m_cap = '0;
    for (int c = 0; c < 1200; c++) begin
      int  wr_pct, rd_pct, n;
      logic pop_req, push_req, err_set, lpop;
      wr_pct = ((c / 200) % 2 == 1) ? 75 : 15;
      rd_pct = ((c / 200) % 2 == 1) ? 10 : 60;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      DACK       = ($urandom_range(0, 7) != 0);
      IOR_N      = 1'($urandom_range(0, 1));
      IOW_N      = 1'($urandom_range(0, 1));
      DB_IN      = 8'($urandom);
      tx_wr_en   = ($urandom_range(0, 99) < wr_pct);
      tx_wr_data = 8'($urandom);
      rx_rd_en   = ($urandom_range(0, 99) < rd_pct);
      tc_clear   = ($urandom_range(0, 31) == 0);
      #1;
      chk("r_db_out", DB_OUT, (tx_m.size() != 0) ? tx_m[0] : 8'h00);
      chk("r_db_oe", DB_OE, DACK & ~IOR_N & ~mode);
      chk("r_tx_full", tx_full, tx_m.size() == 8);
      chk("r_rx_empty", rx_empty, rx_m.size() == 0);
      if (rx_m.size() != 0) chk("r_rx_data", rx_rd_data, rx_m[0]);
      chk("r_err", err_flag, m_err);
      chk("r_dreq", DREQ, 0);
      chk("r_tc", tc_flag, 0);

      pop_req  = DACK & ~mode & ~m_prev_ior & IOR_N;
      push_req = DACK &  mode & ~m_prev_iow & IOW_N;
      err_set  = 0;
      n = tx_m.size();
      if (pop_req) begin
        if (n == 0) err_set = 1;
        else void'(tx_m.pop_front());
      end
      if (tx_wr_en && (n < 8 || (pop_req && n > 0))) tx_m.push_back(tx_wr_data);
      n = rx_m.size();
      lpop = rx_rd_en && (n > 0);
      if (lpop) void'(rx_m.pop_front());
      if (push_req) begin
        if (n < 8 || lpop) rx_m.push_back(m_cap);
        else err_set = 1;
      end
      if (DACK && mode && !IOW_N) m_cap = DB_IN;
      m_err = err_set | (m_err & ~tc_clear);
      m_prev_ior = IOR_N;
      m_prev_iow = IOW_N;
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
